tone_gen: RTL and testbench

- Sample source that feeds the AC-link serializer's PCM slots 3/4.
- Once per AC'97 frame (48 kHz, one `frame_tick` per 256 BIT_CLK cycles) it advances a 16-bit phase accumulator and produces one 20-bit sample.
- The waveform is square, sawtooth or triangle, with switch-selected attenuation.
- Board buttons step the frequency, mute the output and re-phase the generator.
- It replaces the frame-count lookup waveform stage.

---
 rtl/tone_pkg.sv | 36 +++
 rtl/tone_gen_btn_debounce.sv | 47 ++++
 rtl/tone_gen.sv | 93 +++++++++
 tb/tb_tone_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared definitions for the tone generator: waveform codes, sample widths,
// default tuning constants and the raw waveform shaping function.
package tone_pkg;

  typedef enum logic [1:0] {
    WAVE_OFF = 2'b00,
    WAVE_SQR = 2'b01,
    WAVE_SAW = 2'b10,
    WAVE_TRI = 2'b11
  } wave_sel_e;

  localparam int unsigned SAMPLE_W            = 18;
  localparam int unsigned SLOT_W              = 20;
  localparam int unsigned PHASE_W             = 16;
  localparam int unsigned STEP_BASE_DEF       = 137;
  localparam int unsigned NUM_FREQ_DEF        = 16;
  localparam int unsigned DEBOUNCE_FRAMES_DEF = 480;

  // Triangle falling half is the bitwise complement of the rising ramp.
  function automatic logic [SAMPLE_W-1:0] raw_sample(input wave_sel_e sel,
                                                     input logic [PHASE_W-1:0] phase);
    logic [SAMPLE_W-1:0] ramp;
    logic [SAMPLE_W-1:0] res;
    ramp = {phase[PHASE_W-2:0], 3'b000};
    res  = '0;
    case (sel)
      WAVE_OFF: res = '0;
      WAVE_SQR: res = phase[PHASE_W-1] ? '0 : '1;
      WAVE_SAW: res = {phase, 2'b00};
      WAVE_TRI: res = phase[PHASE_W-1] ? ~ramp : ramp;
      default:  res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/tone_gen_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, frame-tick debounce counter and a
// one-cycle pulse on each accepted press.
module btn_debounce
  import tone_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_frame_tick,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_FRAMES + 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync    <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync    <= {r_sync[0], i_btn};
      r_level_d <= r_level;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (i_frame_tick) begin
        // The tick that brings the count to DEBOUNCE_FRAMES accepts the level.
        if (r_cnt == CW'(DEBOUNCE_FRAMES - 1)) begin
          r_level <= r_sync[1];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_press = r_level & ~r_level_d;

endmodule

// File: rtl/tone_gen.sv
// Per-frame PCM tone source: phase accumulator, button-driven frequency/mute
// control and a 2-cycle waveform pipeline feeding slots 3/4.
module tone_gen
  import tone_pkg::*;
#(
  parameter int unsigned STEP_BASE       = STEP_BASE_DEF,
  parameter int unsigned NUM_FREQ        = NUM_FREQ_DEF,
  parameter int unsigned DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF
) (
  input  logic              BIT_CLK,
  input  logic              RESET,
  input  logic              frame_tick,
  input  logic [3:0]        sw,
  input  logic              btnU,
  input  logic              btnD,
  input  logic              btnL,
  input  logic              btnR,
  output logic [SLOT_W-1:0] wave,
  output logic              sample_valid,
  output logic [3:0]        freq_idx,
  output logic              mute
);

  localparam logic [3:0] IDX_MAX = 4'(NUM_FREQ - 1);

  logic                w_up, w_dn, w_mute_tgl, w_resync;
  logic [PHASE_W-1:0]  w_step;
  logic [SAMPLE_W-1:0] w_raw;
  logic [SAMPLE_W-1:0] w_shifted;

  logic [3:0]          r_idx;
  logic                r_mute;
  logic [PHASE_W-1:0]  r_phase;
  logic                r_tick_d;
  logic [SLOT_W-1:0]   r_wave;
  logic                r_valid;

  btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_db_up (
    .i_clk(BIT_CLK), .i_rst_n(RESET), .i_frame_tick(frame_tick), .i_btn(btnU), .o_press(w_up));
  btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_db_dn (
    .i_clk(BIT_CLK), .i_rst_n(RESET), .i_frame_tick(frame_tick), .i_btn(btnD), .o_press(w_dn));
  btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_db_mute (
    .i_clk(BIT_CLK), .i_rst_n(RESET), .i_frame_tick(frame_tick), .i_btn(btnL), .o_press(w_mute_tgl));
  btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_db_sync (
    .i_clk(BIT_CLK), .i_rst_n(RESET), .i_frame_tick(frame_tick), .i_btn(btnR), .o_press(w_resync));

  assign w_step    = 16'(STEP_BASE) * (16'(r_idx) + 16'd1);
  assign w_raw     = raw_sample(wave_sel_e'(sw[1:0]), r_phase);
  assign w_shifted = w_raw >> sw[3:2];

  always_ff @(posedge BIT_CLK or negedge RESET) begin
    if (!RESET) begin
      r_idx  <= '0;
      r_mute <= 1'b0;
    end else begin
      if (w_up && !w_dn && r_idx != IDX_MAX) begin
        r_idx <= r_idx + 4'd1;
      end else if (w_dn && !w_up && r_idx != 4'd0) begin
        r_idx <= r_idx - 4'd1;
      end
      if (w_mute_tgl) begin
        r_mute <= ~r_mute;
      end
    end
  end

  // Re-sync has priority over a coincident frame_tick advance.
  always_ff @(posedge BIT_CLK or negedge RESET) begin
    if (!RESET) begin
      r_phase  <= '0;
      r_tick_d <= 1'b0;
      r_wave   <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_resync) begin
        r_phase <= '0;
      end else if (frame_tick) begin
        r_phase <= r_phase + w_step;
      end
      r_tick_d <= frame_tick;
      r_valid  <= r_tick_d;
      if (r_tick_d) begin
        r_wave <= r_mute ? '0 : {2'b00, w_shifted};
      end
    end
  end

  assign wave         = r_wave;
  assign sample_valid = r_valid;
  assign freq_idx     = r_idx;
  assign mute         = r_mute;

endmodule

// File: tb/tb_tone_gen.sv
// Directed self-checking bench for tone_gen; debounce length is shortened so
// button scenarios stay within a small cycle budget.
module tb_tone_gen;

  localparam int unsigned DBF = 48;

  logic        clk = 1'b0;
  logic        RESET = 1'b0;
  logic        frame_tick = 1'b0;
  logic [3:0]  sw = 4'b0000;
  logic        btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0;
  logic [19:0] wave;
  logic        sample_valid;
  logic [3:0]  freq_idx;
  logic        mute;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] m_phase = '0;
  logic [15:0] m_step = 16'd137;
  int          m_idx = 0;

  tone_gen #(.DEBOUNCE_FRAMES(DBF)) dut (
    .BIT_CLK(clk), .RESET(RESET), .frame_tick(frame_tick), .sw(sw),
    .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
    .wave(wave), .sample_valid(sample_valid), .freq_idx(freq_idx), .mute(mute));

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, time=%0t required < 5ms", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] step_of(input int idx);
    return 16'(137 * (idx + 1));
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    m_phase = m_phase + m_step;
    @(posedge clk); #1;
  endtask

  task automatic tick_sample(output logic [19:0] w, output logic v,
                             output logic vprev, output logic vafter);
    @(posedge clk); #1 frame_tick = 1'b1;
    m_phase = m_phase + m_step;
    @(posedge clk); #1 frame_tick = 1'b0;
    vprev = sample_valid;
    @(posedge clk); #1;
    w = wave;
    v = sample_valid;
    @(posedge clk); #1;
    vafter = sample_valid;
  endtask

  task automatic set_btn(input int which, input logic val);
    case (which)
      0: btnU = val;
      1: btnD = val;
      2: btnL = val;
      3: btnR = val;
      default: begin btnU = val; btnD = val; end
    endcase
  endtask

  // which: 0=U 1=D 2=L 3=R 4=U+D together
  task automatic press(input int which);
    set_btn(which, 1'b1);
    wait_cyc(3);
    repeat (DBF) tick();
    case (which)
      0: if (m_idx < 15) m_idx++;
      1: if (m_idx > 0) m_idx--;
      3: m_phase = '0;
      default: ;
    endcase
    m_step = step_of(m_idx);
    set_btn(which, 1'b0);
    wait_cyc(3);
    repeat (DBF) tick();
  endtask

  task automatic test_reset();
    logic [19:0] w; logic v, vp, va;
    RESET = 1'b0;
    wait_cyc(10);
    checks++; if (wave !== 20'h0 || sample_valid !== 1'b0) begin errors++;
      $display("FAIL reset_wave: wave=%h valid=%b required 00000/0", wave, sample_valid); end
    checks++; if (freq_idx !== 4'd0 || mute !== 1'b0) begin errors++;
      $display("FAIL reset_ctrl: freq_idx=%0d mute=%b required 0/0", freq_idx, mute); end
    sw = 4'b0001;
    RESET = 1'b1;
    m_phase = '0; m_idx = 0; m_step = step_of(0);
    wait_cyc(2);
    tick_sample(w, v, vp, va);
    checks++; if (w !== 20'h3FFFF || v !== 1'b1 || vp !== 1'b0 || va !== 1'b0) begin errors++;
      $display("FAIL first_sample: wave=%h valid(T+1,T+2,T+3)=%b%b%b required 3ffff 010", w, vp, v, va); end
    wait_cyc(20);
    checks++; if (wave !== 20'h3FFFF || sample_valid !== 1'b0) begin errors++;
      $display("FAIL hold_no_tick: wave=%h valid=%b required 3ffff/0", wave, sample_valid); end
    repeat (237) tick();
    tick_sample(w, v, vp, va);
    checks++; if (w !== 20'h3FFFF) begin errors++;
      $display("FAIL square_239: wave=%h required 3ffff (phase 32743)", w); end
    tick_sample(w, v, vp, va);
    checks++; if (w !== 20'h00000 || v !== 1'b1) begin errors++;
      $display("FAIL square_240: wave=%h valid=%b required 00000/1 (phase 32880)", w, v); end
  endtask

  task automatic test_index_low();
    press(1);
    checks++; if (freq_idx !== 4'd0) begin errors++;
      $display("FAIL down_at_zero: freq_idx=%0d required 0", freq_idx); end
  endtask

  task automatic test_sawtooth();
    logic [19:0] w1, w2; logic v, vp, va; logic [15:0] ph1;
    sw = 4'b0010;
    repeat (3) press(0);
    checks++; if (freq_idx !== 4'd3) begin errors++;
      $display("FAIL saw_idx: freq_idx=%0d required 3", freq_idx); end
    tick_sample(w1, v, vp, va);
    ph1 = m_phase;
    checks++; if (w1 !== {2'b00, ph1, 2'b00}) begin errors++;
      $display("FAIL saw_value: wave=%h required %h", w1, {2'b00, ph1, 2'b00}); end
    tick_sample(w2, v, vp, va);
    checks++; if (((w2 - w1) & 20'h3FFFF) !== 20'd2192 || w2[19:18] !== 2'b00) begin errors++;
      $display("FAIL saw_delta: delta=%0d top=%b required 2192/00", (w2 - w1) & 20'h3FFFF, w2[19:18]); end
  endtask

  task automatic test_debounce();
    btnU = 1'b1; wait_cyc(3); tick();
    btnU = 1'b0; wait_cyc(3); repeat (5) tick();
    checks++; if (freq_idx !== 4'd3) begin errors++;
      $display("FAIL glitch: freq_idx=%0d required 3", freq_idx); end
    repeat (5) begin
      btnU = 1'b1; wait_cyc(3); repeat (10) tick();
      btnU = 1'b0; wait_cyc(3); repeat (10) tick();
    end
    checks++; if (freq_idx !== 4'd3) begin errors++;
      $display("FAIL bounce: freq_idx=%0d required 3", freq_idx); end
    press(0);
    checks++; if (freq_idx !== 4'd4) begin errors++;
      $display("FAIL clean_hold: freq_idx=%0d required 4", freq_idx); end
  endtask

  task automatic test_saturation();
    press(4);
    checks++; if (freq_idx !== 4'd4) begin errors++;
      $display("FAIL up_down_same: freq_idx=%0d required 4", freq_idx); end
    for (int i = 0; i < 20; i++) press(0);
    checks++; if (freq_idx !== 4'd15) begin errors++;
      $display("FAIL up_saturate: freq_idx=%0d required 15", freq_idx); end
  endtask

  task automatic test_triangle();
    logic [19:0] w; logic v, vp, va;
    sw = 4'b0111;
    press(3);
    for (int k = 0; k < 5000 && 16'(m_phase + m_step) != 16'd16384; k++) tick();
    tick_sample(w, v, vp, va);
    checks++; if (w !== 20'h10000) begin errors++;
      $display("FAIL tri_16384: wave=%h required 10000", w); end
    for (int k = 0; k < 5000 && 16'(m_phase + m_step) != 16'd49152; k++) tick();
    tick_sample(w, v, vp, va);
    checks++; if (w !== 20'h0FFFF) begin errors++;
      $display("FAIL tri_49152: wave=%h required 0ffff", w); end
  endtask

  task automatic test_mute_resync();
    logic [19:0] w; logic v, vp, va;
    sw = 4'b0010;
    press(2);
    checks++; if (mute !== 1'b1) begin errors++;
      $display("FAIL mute_on: mute=%b required 1", mute); end
    tick_sample(w, v, vp, va);
    checks++; if (w !== 20'h0 || v !== 1'b1) begin errors++;
      $display("FAIL mute_wave: wave=%h valid=%b required 00000/1", w, v); end
    press(2);
    tick_sample(w, v, vp, va);
    checks++; if (mute !== 1'b0 || w !== {2'b00, m_phase, 2'b00}) begin errors++;
      $display("FAIL unmute: mute=%b wave=%h required 0/%h", mute, w, {2'b00, m_phase, 2'b00}); end
    // re-sync pulse lands in the same cycle as a frame_tick
    btnR = 1'b1; wait_cyc(3);
    repeat (DBF - 1) tick();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 frame_tick = 1'b0;
    @(posedge clk); #1;
    m_phase = '0;
    checks++; if (wave !== 20'h0 || sample_valid !== 1'b1) begin errors++;
      $display("FAIL resync_tick: wave=%h valid=%b required 00000/1", wave, sample_valid); end
    btnR = 1'b0; wait_cyc(3);
    repeat (DBF) tick();
  endtask

  task automatic test_reset_midrun();
    logic [19:0] w; logic v, vp, va;
    @(posedge clk); #3 RESET = 1'b0;
    #2;
    checks++; if (wave !== 20'h0 || freq_idx !== 4'd0 || mute !== 1'b0) begin errors++;
      $display("FAIL async_reset: wave=%h freq_idx=%0d mute=%b required 00000/0/0", wave, freq_idx, mute); end
    wait_cyc(3);
    RESET = 1'b1;
    m_phase = '0; m_idx = 0; m_step = step_of(0);
    wait_cyc(2);
    tick_sample(w, v, vp, va);
    checks++; if (w !== 20'd548 || v !== 1'b1) begin errors++;
      $display("FAIL post_reset_sample: wave=%h valid=%b required 00224/1", w, v); end
  endtask

  initial begin
    test_reset();
    test_index_low();
    test_sawtooth();
    test_debounce();
    test_saturation();
    test_triangle();
    test_mute_resync();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
